// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains an 8-bit FIFO (one-cycle read latency) into a valid/ready stream
// through a skid buffer and frames it into BURST_LEN-word bursts. Define FIFO_STREAM_PARITY_EN for m_parity.
module fifo_stream_reader #(
  parameter int SKID_DEPTH = 2,
  parameter int BURST_LEN  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fifo_re,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
`ifdef FIFO_STREAM_PARITY_EN
  output logic        m_parity,
`endif
  output logic [15:0] words_out
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(SKID_DEPTH - 1);
  localparam logic [OW-1:0] DEPTH_W   = OW'(SKID_DEPTH);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

  logic [7:0]    data_r [SKID_DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          inflight_r;
  logic [BW-1:0] beat_r;
  logic [15:0]   words_r;
  logic          pop_s;
  logic [OW-1:0] occ_s;
`ifdef FIFO_STREAM_PARITY_EN
  logic          par_r [SKID_DEPTH];
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

  // Stream view of the buffer head and the read-issue decision.
  always_comb begin
    m_valid   = 1'b0;
    pop_s     = 1'b0;
    occ_s     = {OW{1'b0}};
    fifo_re   = 1'b0;
    m_data    = 8'h00;
    m_last    = 1'b0;
    words_out = words_r;
`ifdef FIFO_STREAM_PARITY_EN
    m_parity  = par_r[rd_ptr_r];
`endif
    m_valid = (count_r != {CW{1'b0}});
    m_data  = data_r[rd_ptr_r];
    pop_s   = m_valid && m_ready;
    // Occupancy after this cycle: held words plus the word arriving, minus the word leaving.
    occ_s   = OW'(count_r) + OW'(inflight_r) - OW'(pop_s);
    if (rst_n && !fifo_empty && (occ_s < DEPTH_W)) begin
      fifo_re = 1'b1;
    end else begin
      fifo_re = 1'b0;
    end
    if (m_valid && (beat_r == BEAT_LAST)) begin
      m_last = 1'b1;
    end else begin
      m_last = 1'b0;
    end
  end

  // Skid buffer storage: captures the word of the read issued last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_r[i] <= 8'h00;
`ifdef FIFO_STREAM_PARITY_EN
        par_r[i]  <= 1'b0;
`endif
      end
    end else if (inflight_r) begin
      data_r[wr_ptr_r] <= fifo_dout;
`ifdef FIFO_STREAM_PARITY_EN
      par_r[wr_ptr_r]  <= parity8(fifo_dout);
`endif
    end
  end

  // Pointers, occupancy, in-flight flag, burst beat and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      inflight_r <= 1'b0;
      beat_r     <= {BW{1'b0}};
      words_r    <= 16'h0000;
    end else begin
      count_r    <= CW'(occ_s);
      inflight_r <= fifo_re;
      if (inflight_r) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
        words_r  <= words_r + 16'd1;
        if (beat_r == BEAT_LAST) begin
          beat_r <= {BW{1'b0}};
        end else begin
          beat_r <= beat_r + BW'(1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader (SKID_DEPTH=2, BURST_LEN=8) with a behavioural FIFO
// and a pop scoreboard; parity is also checked when FIFO_STREAM_PARITY_EN is defined.
module tb_fifo_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        fifo_re;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] words_out;
`ifdef FIFO_STREAM_PARITY_EN
  logic        m_parity;
`endif

  logic [7:0] mem [0:1023];
  int rd_idx = 0;
  int wr_idx = 0;
  int exp_idx = 0;
  int exp_beat = 0;
  int n_cmp = 0;
  int n_fail = 0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  fifo_stream_reader #(.SKID_DEPTH(2), .BURST_LEN(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_re    (fifo_re),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
`ifdef FIFO_STREAM_PARITY_EN
    .m_parity   (m_parity),
`endif
    .words_out  (words_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (rd_idx == wr_idx);

  initial fifo_dout = 8'h00;
  always @(posedge clk) begin
    if (fifo_re && !fifo_empty) begin
      fifo_dout <= mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_idx] = v;
    wr_idx++;
  endtask

  // Scoreboard: order, burst marker, hold-while-stalled and read-while-empty on every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("re_while_empty", 16'(fifo_re && fifo_empty), 16'd0);
      if (hold_v) begin
        chk("hold_valid", 16'(m_valid), 16'd1);
        chk("hold_data", 16'(m_data), 16'(hold_d));
      end
      if (m_valid && m_ready) begin
        chk("pop_in_range", 16'(exp_idx < wr_idx), 16'd1);
        if (exp_idx < wr_idx) begin
          chk("pop_data", 16'(m_data), 16'(mem[exp_idx]));
`ifdef FIFO_STREAM_PARITY_EN
          chk("pop_parity", 16'(m_parity), 16'(^mem[exp_idx]));
`endif
        end
        chk("pop_last", 16'(m_last), 16'(exp_beat == 7));
        exp_idx++;
        exp_beat = (exp_beat == 7) ? 0 : exp_beat + 1;
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_idx  = rd_idx;
    exp_beat = 0;
    rst_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int reads;
    int first;

    // Test 1: reset values with a non-empty FIFO, then three words.
    rst_n   = 1'b0;
    m_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33);
    @(negedge clk);
    chk("rst_fifo_re", 16'(fifo_re), 16'd0);
    chk("rst_m_valid", 16'(m_valid), 16'd0);
    chk("rst_m_data", 16'(m_data), 16'h00);
    chk("rst_m_last", 16'(m_last), 16'd0);
    chk("rst_words", words_out, 16'd0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("t1_c0_re", 16'(fifo_re), 16'd1);
    chk("t1_c0_valid", 16'(m_valid), 16'd0);
    @(negedge clk);
    chk("t1_c1_valid", 16'(m_valid), 16'd0);
    @(negedge clk);
    chk("t1_c2_valid", 16'(m_valid), 16'd1);
    chk("t1_c2_data", 16'(m_data), 16'h11);
    @(negedge clk);
    chk("t1_c3_data", 16'(m_data), 16'h22);
    chk("t1_c3_re", 16'(fifo_re), 16'd0);
    @(negedge clk);
    chk("t1_c4_data", 16'(m_data), 16'h33);
    chk("t1_c4_valid", 16'(m_valid), 16'd1);
    @(negedge clk);
    chk("t1_c5_valid", 16'(m_valid), 16'd0);
    chk("t1_words", words_out, 16'd3);

    // Test 2: 20 words back to back, m_last on words 8 and 16.
    do_reset();
    first = wr_idx;
    for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
    m_ready = 1'b1;
    @(negedge clk);
    t = 0;
    while (m_valid !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("t2_start", 16'(m_valid), 16'd1);
    for (int k = 1; k <= 20; k++) begin
      chk("t2_valid", 16'(m_valid), 16'd1);
      chk("t2_data", 16'(m_data), 16'(mem[first + k - 1]));
      chk("t2_last", 16'(m_last), 16'((k % 8) == 0));
      @(negedge clk);
    end
    chk("t2_idle", 16'(m_valid), 16'd0);
    chk("t2_words", words_out, 16'd20);

    // Test 3: stall 10 cycles with 6 words queued; only two reads may be issued.
    @(posedge clk); #1;
    m_ready = 1'b0;
    first = wr_idx;
    for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
    reads = 0;
    repeat (10) begin
      @(negedge clk);
      if (fifo_re && !fifo_empty) reads++;
    end
    chk("t3_reads", 16'(reads), 16'd2);
    chk("t3_valid", 16'(m_valid), 16'd1);
    chk("t3_head", 16'(m_data), 16'(mem[first]));
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("t3_reuse_re", 16'(fifo_re), 16'd1);
    t = 0;
    while (exp_idx < wr_idx && t < 60) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("t3_words", words_out, 16'd26);

    // Test 5: reset mid-burst with a read in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_fifo_re", 16'(fifo_re), 16'd0);
    chk("t5_m_valid", 16'(m_valid), 16'd0);
    chk("t5_m_data", 16'(m_data), 16'h00);
    chk("t5_m_last", 16'(m_last), 16'd0);
    chk("t5_words", words_out, 16'd0);
    chk("t5_rd_idx", 16'(rd_idx), 16'(wr_idx - 2));
    exp_idx  = rd_idx;
    exp_beat = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    while (exp_idx < wr_idx && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("t5_after_words", words_out, 16'd2);

    // Test 4: 500 random words, random back-pressure, bursty FIFO fill.
    do_reset();
    t = 0;
    begin
      int pushed;
      pushed = 0;
      while ((pushed < 500 || exp_idx < wr_idx) && t < 5000) begin
        if (pushed < 500 && $urandom_range(0, 3) != 0) begin
          push(8'($urandom_range(0, 255)));
          pushed++;
        end
        m_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        t++;
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_no_timeout", 16'(t < 5000), 16'd1);
    chk("t4_words", words_out, 16'd500);
    chk("t4_idle", 16'(m_valid), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain-side controller for the team's 8-bit synchronous FIFO: issues FIFO reads (`re`/`empty`/`dout` protocol, one-cycle read latency) and re-presents the words as a valid/ready stream toward downstream consumers (UART TX, SPI master, packet formatters). A small skid buffer absorbs the FIFO read latency so back-pressure never drops or duplicates a word. The block also frames the stream into fixed-length bursts with a last-word marker.

## Interface
Parameters:
- `SKID_DEPTH`, 2: skid buffer entries; legal values 2 or 4.
- `BURST_LEN`, 8: words per burst; legal range 1..256.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion synchronous to `clk` is the integrator's job.
- `fifo_re`  out  1  read request to FIFO; asserted only when `fifo_empty` is low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  8  FIFO read data, valid the cycle after an accepted read.
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  consumer accepts word.
- `m_data`  out  8  stream word.
- `m_last`  out  1  high with the final word of each burst.
- `words_out`  out  16  count of stream handshakes, wraps at 65535→0.

## Operation
- Accepted read: `fifo_re && !fifo_empty` in cycle N; word sampled from `fifo_dout` at the end of cycle N+1 into the skid buffer (FIFO order preserved).
- Internal counts: `count` (entries held, 0..SKID_DEPTH), `inflight` (0 or 1: read accepted last cycle, not yet captured), `pop` = `m_valid && m_ready`.
- Read issue rule: `fifo_re = !fifo_empty && (count + inflight - pop) < SKID_DEPTH`; combinational, so no overflow is possible in any sequence.
- Stream: `m_valid = (count != 0)`; `m_data` = oldest entry; once asserted, `m_valid` and `m_data` hold stable until `pop`.
- Simultaneous capture and pop: both applied; `count` unchanged, head advances.
- Burst counter `beat` (width clog2(BURST_LEN), min 1): increments on `pop`; on `pop` with `beat == BURST_LEN-1` wraps to 0. `m_last = m_valid && (beat == BURST_LEN-1)`. BURST_LEN=1 → `m_last` equals `m_valid`.
- `words_out` increments by 1 on each `pop`, modulo 2^16.
- Buffer pointers wrap modulo SKID_DEPTH.
- The attached FIFO must honour every read presented with `empty` low in the same cycle; FIFOs giving write priority over read are wrapped to do so before connection.

## Timing
- Reset (`rst_n` low, any cycle, mid-burst included): `fifo_re`=0 (forced), `m_valid`=0, `m_data`=0x00, `m_last`=0, `words_out`=0, `count`=0, `inflight`=0, `beat`=0; a read in flight at reset is discarded.
- First-word latency: `fifo_re` in cycle N → `m_valid` high in cycle N+2.
- Throughput: 1 word/cycle sustained with `m_ready` held high and FIFO non-empty.
- `m_ready` low: at most SKID_DEPTH words buffered; `fifo_re` stays low until a slot frees (same-cycle reuse via `pop`).
- FIFO goes empty: `fifo_re` drops the same cycle; buffered words still drain normally.

## Configuration
- `FIFO_STREAM_PARITY_EN` defined: extra output `m_parity` (1 bit) = XOR of stored `m_data` bits (even parity), computed at capture, stored per entry, reset 0.
- Not defined: no `m_parity` port, no parity storage; behaviour otherwise identical.

## Test plan
- Reset then FIFO holding 0x11,0x22,0x33, `m_ready`=1 → `fifo_re` cycle 0; `m_valid` cycles 2-4 with 0x11,0x22,0x33; `words_out`=3; `fifo_re` low after empty.
- 20 words, `m_ready`=1, BURST_LEN=8 → one word per cycle, no gaps; `m_last` on words 8 and 16; `beat`=4 at end.
- `m_ready` low 10 cycles with 6 words queued → exactly SKID_DEPTH reads issued, `m_data` stable; release → words in order, none lost or duplicated.
- Random `m_ready` (50%), 500 random words → scoreboard exact order; `fifo_re` never high while `fifo_empty` high; `words_out`=500.
- `rst_n` low mid-burst with a read in flight → all outputs at reset values immediately; after release next burst starts with `beat`=0.
- With `FIFO_STREAM_PARITY_EN`: words 0x00,0x01,0xFF,0x07 → `m_parity` 0,1,0,1.
